// File: rtl/pipe_pkg.sv
// Shared types and default widths for the EX/MEM handshake pipeline register.
// The payload struct packs fields MSB-first as wb, m, rd, rs2_data, alu_result, adder_sum.
package pipe_pkg;

  localparam int DATA_BITS_DEF = 32;
  localparam int RD_BITS_DEF   = 5;
  localparam int M_BITS_DEF    = 3;
  localparam int WB_BITS_DEF   = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic [WB_BITS_DEF-1:0]   wb;
    logic [M_BITS_DEF-1:0]    m;
    logic [RD_BITS_DEF-1:0]   rd;
    logic [DATA_BITS_DEF-1:0] rs2_data;
    logic [DATA_BITS_DEF-1:0] alu_result;
    logic [DATA_BITS_DEF-1:0] adder_sum;
  } ex_mem_payload_t;

  function automatic int payload_bits(input int data_bits, input int rd_bits,
                                      input int m_bits, input int wb_bits);
    return 3 * data_bits + rd_bits + m_bits + wb_bits;
  endfunction

endpackage

// File: rtl/pipeline_register_hs_if.sv
// Valid/ready handshake bundle carrying one EX/MEM payload.
// The producer side uses the master modport, the consumer side uses slave.
interface pipeline_register_hs_if
  import pipe_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int RD_BITS   = RD_BITS_DEF,
  parameter int M_BITS    = M_BITS_DEF,
  parameter int WB_BITS   = WB_BITS_DEF
);

  logic                 valid;
  logic                 ready;
  logic [DATA_BITS-1:0] adder_sum;
  logic [DATA_BITS-1:0] alu_result;
  logic [DATA_BITS-1:0] rs2_data;
  logic [RD_BITS-1:0]   rd;
  logic [M_BITS-1:0]    m;
  logic [WB_BITS-1:0]   wb;

  modport master (
    output valid, adder_sum, alu_result, rs2_data, rd, m, wb,
    input  ready
  );

  modport slave (
    input  valid, adder_sum, alu_result, rs2_data, rd, m, wb,
    output ready
  );

endinterface

// File: rtl/pipe_skid_stage.sv
// One register stage with a main entry and a skid entry (EMPTY/ONE/FULL).
// Every output is a flop so stages chain without combinational paths.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  stage_state_t     state, state_nx;
  logic [WIDTH-1:0] main_q, main_nx;
  logic [WIDTH-1:0] skid_q, skid_nx;
  logic             accept, drain;

  assign accept   = in_valid & in_ready;
  assign drain    = out_valid & out_ready;
  assign out_data = main_q;

  // main_q is kept at zero whenever the stage is empty, so out_data needs no mask
  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) begin
      state_nx = ST_EMPTY;
      main_nx  = '0;
      skid_nx  = '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_nx  = in_data;
            state_nx = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_nx = in_data;
          end else if (accept) begin
            skid_nx  = in_data;
            state_nx = ST_FULL;
          end else if (drain) begin
            main_nx  = '0;
            state_nx = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_nx  = skid_q;
            skid_nx  = '0;
            state_nx = ST_ONE;
          end
        end
        default: begin
          state_nx = ST_EMPTY;
          main_nx  = '0;
          skid_nx  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      main_q    <= main_nx;
      skid_q    <= skid_nx;
      in_ready  <= (state_nx != ST_FULL);
      out_valid <= (state_nx != ST_EMPTY);
    end
  end

endmodule

// File: rtl/pipeline_register_hs.sv
// EX/MEM pipeline register: DEPTH cascaded skid stages with flush and occupancy.
// Holds up to 2*DEPTH entries in strict FIFO order.
module pipeline_register_hs
  import pipe_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int RD_BITS   = RD_BITS_DEF,
  parameter int M_BITS    = M_BITS_DEF,
  parameter int WB_BITS   = WB_BITS_DEF,
  parameter int DEPTH     = 1
) (
  input  logic                             clk,
  input  logic                             n_reset,
  input  logic                             flush,
  pipeline_register_hs_if.slave            pipe_in,
  pipeline_register_hs_if.master           pipe_out,
  output logic [$clog2(2*DEPTH+1)-1:0]     occupancy
);

  localparam int PW       = payload_bits(DATA_BITS, RD_BITS, M_BITS, WB_BITS);
  localparam int OCC_BITS = $clog2(2*DEPTH+1);

  logic [PW-1:0] in_data;
  logic [PW-1:0] s_data  [DEPTH];
  logic          s_valid [DEPTH];
  logic          s_ready [DEPTH];
  logic          accept, drain;

  assign in_data = {pipe_in.wb, pipe_in.m, pipe_in.rd,
                    pipe_in.rs2_data, pipe_in.alu_result, pipe_in.adder_sum};

  // Stage k consumes stage k-1's output and is drained by stage k+1's ready
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          st_in_valid;
    logic          st_out_ready;
    logic [PW-1:0] st_in_data;

    if (k == 0) begin : g_head
      assign st_in_valid = pipe_in.valid;
      assign st_in_data  = in_data;
    end else begin : g_link
      assign st_in_valid = s_valid[k-1];
      assign st_in_data  = s_data[k-1];
    end

    if (k == DEPTH - 1) begin : g_tail
      assign st_out_ready = pipe_out.ready;
    end else begin : g_next
      assign st_out_ready = s_ready[k+1];
    end

    pipe_skid_stage #(.WIDTH(PW)) u_stage (
      .clk       (clk),
      .n_reset   (n_reset),
      .flush     (flush),
      .in_valid  (st_in_valid),
      .in_ready  (s_ready[k]),
      .in_data   (st_in_data),
      .out_valid (s_valid[k]),
      .out_ready (st_out_ready),
      .out_data  (s_data[k])
    );
  end

  assign pipe_in.ready  = s_ready[0];
  assign pipe_out.valid = s_valid[DEPTH-1];
  assign {pipe_out.wb, pipe_out.m, pipe_out.rd,
          pipe_out.rs2_data, pipe_out.alu_result, pipe_out.adder_sum} = s_data[DEPTH-1];

  assign accept = pipe_in.valid & s_ready[0];
  assign drain  = s_valid[DEPTH-1] & pipe_out.ready;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_BITS'(accept) - OCC_BITS'(drain);
    end
  end

endmodule

// File: tb/tb_pipeline_register_hs.sv
// Bench for pipeline_register_hs: four DUT lanes (DEPTH 1..4) checked every cycle
// against a per-stage queue model, plus directed cases with literal expectations.
module tb_pipeline_register_hs;
  import pipe_pkg::*;

  localparam int PW    = $bits(ex_mem_payload_t);
  localparam int LANES = 4;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  logic          drv_valid [LANES];
  logic          drv_ready [LANES];
  logic          drv_flush [LANES];
  logic [PW-1:0] drv_data  [LANES];

  logic          obs_in_ready  [LANES];
  logic          obs_out_valid [LANES];
  logic [PW-1:0] obs_out_data  [LANES];
  logic [3:0]    obs_occ       [LANES];

  int n_compared = 0;
  int n_mismatch = 0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int D  = g + 1;
    localparam int OB = $clog2(2*D+1);
    pipeline_register_hs_if up_if ();
    pipeline_register_hs_if dn_if ();
    logic [OB-1:0] occ;

    assign up_if.valid = drv_valid[g];
    assign {up_if.wb, up_if.m, up_if.rd, up_if.rs2_data, up_if.alu_result, up_if.adder_sum} = drv_data[g];
    assign dn_if.ready = drv_ready[g];

    pipeline_register_hs #(
      .DATA_BITS (DATA_BITS_DEF),
      .RD_BITS   (RD_BITS_DEF),
      .M_BITS    (M_BITS_DEF),
      .WB_BITS   (WB_BITS_DEF),
      .DEPTH     (D)
    ) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .flush     (drv_flush[g]),
      .pipe_in   (up_if),
      .pipe_out  (dn_if),
      .occupancy (occ)
    );

    assign obs_in_ready[g]  = up_if.ready;
    assign obs_out_valid[g] = dn_if.valid;
    assign obs_out_data[g]  = {dn_if.wb, dn_if.m, dn_if.rd, dn_if.rs2_data, dn_if.alu_result, dn_if.adder_sum};
    assign obs_occ[g]       = 4'(occ);
  end

  // Reference model: lane l, stage s is the queue mq[l*4+s], each holding at most two entries
  logic [PW-1:0] mq [LANES*4][$];
  bit            started [LANES];

  function automatic int occOf(input int l);
    int sum = 0;
    for (int s = 0; s <= l; s++) sum += mq[l*4+s].size();
    return sum;
  endfunction

  task automatic modelStep(input int l);
    int d = l + 1;
    bit rdy [4];
    bit mv  [4];
    bit acc;
    logic [PW-1:0] item;
    if (drv_flush[l]) begin
      for (int s = 0; s < 4; s++) mq[l*4+s].delete();
      started[l] = 1'b1;
      return;
    end
    for (int s = 0; s < d; s++) rdy[s] = started[l] && (mq[l*4+s].size() < 2);
    for (int s = 0; s < d; s++)
      mv[s] = (mq[l*4+s].size() > 0) && ((s == d-1) ? (drv_ready[l] == 1'b1) : rdy[s+1]);
    acc = (drv_valid[l] == 1'b1) && rdy[0];
    for (int s = d-1; s >= 0; s--) begin
      if (mv[s]) begin
        item = mq[l*4+s].pop_front();
        if (s < d-1) mq[l*4+s+1].push_back(item);
      end
    end
    if (acc) mq[l*4].push_back(drv_data[l]);
    started[l] = 1'b1;
  endtask

  always @(posedge clk or negedge n_reset) begin
    for (int l = 0; l < LANES; l++) begin
      if (!n_reset) begin
        for (int s = 0; s < 4; s++) mq[l*4+s].delete();
        started[l] = 1'b0;
      end else begin
        modelStep(l);
      end
    end
  end

  task automatic checkOutput(input string what, input int lane,
                             input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatch++;
      $display("[TB] FAIL %s lane%0d (depth %0d): actual %h, expected %h", what, lane, lane+1, act, exp);
    end
  endtask

  // Per-cycle comparison of every lane against the model
  always @(negedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      logic          exp_valid;
      logic [PW-1:0] exp_data;
      exp_valid = mq[l*4+l].size() > 0;
      exp_data  = exp_valid ? mq[l*4+l][0] : '0;
      checkOutput("out_valid", l, PW'(obs_out_valid[l]), PW'(exp_valid));
      checkOutput("out_data",  l, obs_out_data[l], exp_data);
      checkOutput("in_ready",  l, PW'(obs_in_ready[l]), PW'(started[l] && mq[l*4].size() < 2));
      checkOutput("occupancy", l, PW'(obs_occ[l]), PW'(occOf(l)));
    end
  end

  function automatic ex_mem_payload_t mk(input logic [4:0] rd, input logic [31:0] alu);
    ex_mem_payload_t p;
    p            = '0;
    p.rd         = rd;
    p.alu_result = alu;
    p.adder_sum  = alu + 32'h100;
    p.rs2_data   = ~alu;
    p.m          = rd[2:0];
    p.wb         = alu[1:0];
    return p;
  endfunction

  task automatic applyStimulus(input int lane, input logic v, input logic r,
                               input logic f, input ex_mem_payload_t p);
    drv_valid[lane] = v;
    drv_ready[lane] = r;
    drv_flush[lane] = f;
    drv_data[lane]  = p;
  endtask

  ex_mem_payload_t obs_p;

  initial begin
    for (int l = 0; l < LANES; l++) applyStimulus(l, 1'b0, 1'b0, 1'b0, '0);

    // Reset: in_ready low while held, high after the first edge following release
    repeat (2) @(negedge clk);
    checkOutput("lit_ready_in_reset", 0, PW'(obs_in_ready[0]), PW'(1'b0));
    n_reset = 1'b1;
    @(negedge clk);
    checkOutput("lit_ready_after_reset", 0, PW'(obs_in_ready[0]), PW'(1'b1));
    checkOutput("lit_occ_after_reset", 0, PW'(obs_occ[0]), PW'(0));

    // DEPTH=1 back-to-back 0x10,0x11,0x12 with out_ready high
    applyStimulus(0, 1'b1, 1'b1, 1'b0, mk(5'd1, 32'h10));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs_p = obs_out_data[0];
      checkOutput("lit_b2b_valid", 0, PW'(obs_out_valid[0]), PW'(1'b1));
      checkOutput("lit_b2b_alu", 0, PW'(obs_p.alu_result), PW'(32'h10 + i));
      if (i < 2) applyStimulus(0, 1'b1, 1'b1, 1'b0, mk(5'd1, 32'h11 + i));
      else       applyStimulus(0, 1'b0, 1'b1, 1'b0, '0);
    end
    @(negedge clk);
    checkOutput("lit_b2b_idle", 0, PW'(obs_out_valid[0]), PW'(1'b0));

    // DEPTH=2 stalled: 5 offered, 4 accepted, then drained in order
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b1, 1'b0, 1'b0, mk(5'd2, 32'h20 + i));
      if (i == 4) checkOutput("lit_fill_ready_low", 1, PW'(obs_in_ready[1]), PW'(1'b0));
      @(negedge clk);
    end
    obs_p = obs_out_data[1];
    checkOutput("lit_fill_occ", 1, PW'(obs_occ[1]), PW'(4));
    checkOutput("lit_fill_head", 1, PW'(obs_p.alu_result), PW'(32'h20));
    applyStimulus(1, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      obs_p = obs_out_data[1];
      checkOutput("lit_drain_valid", 1, PW'(obs_out_valid[1]), PW'(1'b1));
      checkOutput("lit_drain_alu", 1, PW'(obs_p.alu_result), PW'(32'h20 + i));
    end
    @(negedge clk);
    checkOutput("lit_drain_empty", 1, PW'(obs_occ[1]), PW'(0));

    // DEPTH=1 FULL, then flush together with an rd=7 push
    applyStimulus(0, 1'b1, 1'b0, 1'b0, mk(5'd1, 32'h30));
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, mk(5'd2, 32'h31));
    @(negedge clk);
    checkOutput("lit_full_ready", 0, PW'(obs_in_ready[0]), PW'(1'b0));
    checkOutput("lit_full_occ", 0, PW'(obs_occ[0]), PW'(2));
    applyStimulus(0, 1'b1, 1'b1, 1'b1, mk(5'd7, 32'h37));
    @(negedge clk);
    obs_p = obs_out_data[0];
    checkOutput("lit_flush_valid", 0, PW'(obs_out_valid[0]), PW'(1'b0));
    checkOutput("lit_flush_rd", 0, PW'(obs_p.rd), PW'(0));
    checkOutput("lit_flush_occ", 0, PW'(obs_occ[0]), PW'(0));
    checkOutput("lit_flush_ready", 0, PW'(obs_in_ready[0]), PW'(1'b1));
    applyStimulus(0, 1'b0, 1'b1, 1'b0, '0);
    repeat (3) @(negedge clk);
    checkOutput("lit_flush_no_rd7", 0, PW'(obs_out_valid[0]), PW'(1'b0));

    // DEPTH=2 holding 3 entries, asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1'b1, 1'b0, 1'b0, mk(5'd3, 32'h40 + i));
      @(negedge clk);
    end
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("lit_pre_reset_occ", 1, PW'(obs_occ[1]), PW'(3));
    #2 n_reset = 1'b0;
    #1;
    checkOutput("lit_async_valid", 1, PW'(obs_out_valid[1]), PW'(1'b0));
    checkOutput("lit_async_data", 1, obs_out_data[1], '0);
    checkOutput("lit_async_occ", 1, PW'(obs_occ[1]), PW'(0));
    checkOutput("lit_async_ready", 1, PW'(obs_in_ready[1]), PW'(1'b0));
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    checkOutput("lit_release_ready", 1, PW'(obs_in_ready[1]), PW'(1'b1));
    checkOutput("lit_release_occ", 1, PW'(obs_occ[1]), PW'(0));

    // Random traffic on all lanes; drain pressure alternates every 500 cycles
    for (int c = 0; c < 10000; c++) begin
      int rp;
      rp = ((c / 500) % 2 == 1) ? 85 : 35;
      for (int l = 0; l < LANES; l++) begin
        applyStimulus(l,
                      $urandom_range(0, 99) < 60,
                      $urandom_range(0, 99) < rp,
                      $urandom_range(0, 199) == 0,
                      PW'({$urandom(), $urandom(), $urandom(), $urandom()}));
      end
      @(negedge clk);
    end

    for (int l = 0; l < LANES; l++) applyStimulus(l, 1'b0, 1'b1, 1'b0, '0);
    repeat (20) @(negedge clk);
    for (int l = 0; l < LANES; l++)
      checkOutput("final_empty", l, PW'(obs_occ[l]), PW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
